// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM: fetch/decode/exec/mem/wb/branch.
// Ports: clk, rst (sync, active-high), op/fun instruction fields,
//   equal/sign ALU flags, mem_ready handshake; outputs are datapath
//   enables/selects, ALUctr, illegal pulse and current state.
module multicycle_control (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic [5:0] fun,
   input  logic       equal,
   input  logic       sign,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       IRWr,
   output logic       PCWr,
   output logic       nPC_sel,
   output logic       RegWr,
   output logic       RegDst,
   output logic       ExtOp,
   output logic       ALUSrc,
   output logic       MemWr,
   output logic       MemtoReg,
   output logic [2:0] ALUctr,
   output logic       illegal,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_BRANCH = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      C_ILL  = 3'd0,
      C_R    = 3'd1,
      C_ADDI = 3'd2,
      C_LW   = 3'd3,
      C_SW   = 3'd4,
      C_BEQ  = 3'd5,
      C_BNE  = 3'd6,
      C_BGTZ = 3'd7
   } cls_t;

   state_t     cur;
   cls_t       cls;
   logic [2:0] alu;
   cls_t       dec_cls;
   logic [2:0] dec_alu;
   logic       taken;

   // Instruction classification, only latched during DECODE
   always_comb begin
      dec_cls = C_ILL;
      dec_alu = 3'd0;
      case (op)
         6'b000000: begin
            dec_cls = C_R;
            case (fun)
               6'b100000: dec_alu = 3'd2;
               6'b100001: dec_alu = 3'd4;
               6'b100010: dec_alu = 3'd6;
               6'b100011: dec_alu = 3'd6;
               6'b100100: dec_alu = 3'd0;
               6'b100101: dec_alu = 3'd1;
               6'b000000: dec_alu = 3'd5;
               6'b101010: dec_alu = 3'd3;
               6'b101011: dec_alu = 3'd7;
               default:   dec_cls = C_ILL;
            endcase
         end
         6'b001000: begin dec_cls = C_ADDI; dec_alu = 3'd2; end
         6'b100011: begin dec_cls = C_LW;   dec_alu = 3'd4; end
         6'b101011: begin dec_cls = C_SW;   dec_alu = 3'd4; end
         6'b000100: begin dec_cls = C_BEQ;  dec_alu = 3'd6; end
         6'b000101: begin dec_cls = C_BNE;  dec_alu = 3'd6; end
         6'b000111: begin dec_cls = C_BGTZ; dec_alu = 3'd6; end
         default:   dec_cls = C_ILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur <= S_FETCH;
         cls <= C_ILL;
         alu <= 3'd0;
      end else begin
         case (cur)
            S_FETCH:
               if (mem_ready) cur <= S_DECODE;
            S_DECODE: begin
               cls <= dec_cls;
               alu <= dec_alu;
               case (dec_cls)
                  C_ILL:               cur <= S_FETCH;
                  C_BEQ, C_BNE, C_BGTZ: cur <= S_BRANCH;
                  default:             cur <= S_EXEC;
               endcase
            end
            S_EXEC:
               if (cls == C_LW || cls == C_SW) cur <= S_MEM;
               else                            cur <= S_WB;
            S_MEM:
               if (mem_ready) begin
                  if (cls == C_SW) cur <= S_FETCH;
                  else             cur <= S_WB;
               end
            S_WB:     cur <= S_FETCH;
            S_BRANCH: cur <= S_FETCH;
            default:  cur <= S_FETCH;
         endcase
      end
   end

   // bgtz compares rs against zero: taken when neither zero nor negative
   always_comb begin
      case (cls)
         C_BEQ:   taken = equal;
         C_BNE:   taken = ~equal;
         C_BGTZ:  taken = ~equal & ~sign;
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      mem_req  = 1'b0;
      IRWr     = 1'b0;
      PCWr     = 1'b0;
      nPC_sel  = 1'b0;
      RegWr    = 1'b0;
      RegDst   = 1'b0;
      ExtOp    = 1'b0;
      ALUSrc   = 1'b0;
      MemWr    = 1'b0;
      MemtoReg = 1'b0;
      ALUctr   = 3'd0;
      illegal  = 1'b0;
      case (cur)
         S_FETCH: begin
            mem_req = 1'b1;
            IRWr    = mem_ready;
            PCWr    = mem_ready;
         end
         S_DECODE:
            illegal = (dec_cls == C_ILL);
         S_EXEC: begin
            ALUctr = alu;
            if (cls == C_R) begin
               RegDst = 1'b1;
            end else begin
               ALUSrc = 1'b1;
               ExtOp  = 1'b1;
            end
         end
         S_MEM: begin
            mem_req = 1'b1;
            MemWr   = (cls == C_SW);
         end
         S_WB: begin
            RegWr    = 1'b1;
            MemtoReg = (cls == C_LW);
            RegDst   = (cls == C_R);
         end
         S_BRANCH: begin
            ALUctr  = 3'd6;
            PCWr    = taken;
            nPC_sel = taken;
         end
         default: ;
      endcase
   end

   assign state = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected
// outputs come from an instruction-level model of the control flow.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] op = 6'd0;
   logic [5:0] fun = 6'd0;
   logic       equal = 1'b0;
   logic       sign = 1'b0;
   logic       mem_ready = 1'b1;
   logic       mem_req, IRWr, PCWr, nPC_sel, RegWr, RegDst;
   logic       ExtOp, ALUSrc, MemWr, MemtoReg, illegal;
   logic [2:0] ALUctr, state;

   multicycle_control dut (
      .clk(clk), .rst(rst), .op(op), .fun(fun),
      .equal(equal), .sign(sign), .mem_ready(mem_ready),
      .mem_req(mem_req), .IRWr(IRWr), .PCWr(PCWr),
      .nPC_sel(nPC_sel), .RegWr(RegWr), .RegDst(RegDst),
      .ExtOp(ExtOp), .ALUSrc(ALUSrc), .MemWr(MemWr),
      .MemtoReg(MemtoReg), .ALUctr(ALUctr),
      .illegal(illegal), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] st;
      logic       mem_req, ir, pc, npc, rw, rd, ext, src, mw, m2r;
      logic [2:0] alu;
      logic       ill;
   } rec_t;

   localparam int K_R = 0, K_ADDI = 1, K_LW = 2, K_SW = 3;
   localparam int K_BEQ = 4, K_BNE = 5, K_BGTZ = 6, K_ILL = 7;

   rec_t  exp_q[$];
   string tag_q[$];
   int    total = 0;
   int    bad = 0;

   // Instruction tables (ALU codes: and0 or1 add2 slt3 addu4 sll5 sub6 sltu7)
   logic [5:0] r_fun [9] = '{6'b100000, 6'b100001, 6'b100010,
                             6'b100011, 6'b100100, 6'b100101,
                             6'b000000, 6'b101010, 6'b101011};
   logic [2:0] r_alu [9] = '{3'd2, 3'd4, 3'd6, 3'd6, 3'd0,
                             3'd1, 3'd5, 3'd3, 3'd7};
   logic [5:0] i_op  [7] = '{6'd0, 6'b001000, 6'b100011, 6'b101011,
                             6'b000100, 6'b000101, 6'b000111};
   logic [2:0] i_alu [7] = '{3'd0, 3'd2, 3'd4, 3'd4, 3'd6, 3'd6, 3'd6};
   logic [5:0] bad_op [4] = '{6'b111111, 6'b000010, 6'b001101, 6'b100000};
   logic [5:0] bad_fn [3] = '{6'b100110, 6'b000010, 6'b100111};

   always @(negedge clk) begin : monitor
      rec_t  e, g;
      string t;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         g = {state, mem_req, IRWr, PCWr, nPC_sel, RegWr, RegDst,
              ExtOp, ALUSrc, MemWr, MemtoReg, ALUctr, illegal};
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL %s t=%0t: got=%h (st %0d) want=%h (st %0d)",
                     t, $time, g, g.st, e, e.st);
         end
      end
   end

   function automatic rec_t blank(input logic [2:0] s);
      rec_t r;
      r = '0;
      r.st = s;
      return r;
   endfunction

   // One cycle: don't-care inputs get random junk
   task automatic drive(input logic mr, input logic r);
      @(posedge clk);
      #1;
      rst       = r;
      mem_ready = mr;
      op        = 6'($urandom);
      fun       = 6'($urandom);
      equal     = 1'($urandom);
      sign      = 1'($urandom);
   endtask

   task automatic push(input rec_t e, input string t);
      exp_q.push_back(e);
      tag_q.push_back(t);
   endtask

   // abort: 0 none, 1 reset at fetch with mem_ready=1, 2 reset in MEM wait
   task automatic run(input int k, input logic [5:0] o,
                      input logic [5:0] f, input logic [2:0] a,
                      input logic eq, input logic sg, input int fw,
                      input int mw, input int abort, input string t);
      rec_t e;
      logic tk;
      for (int i = 0; i < fw; i++) begin
         drive(1'b0, 1'b0);
         e = blank(3'd0); e.mem_req = 1'b1;
         push(e, t);
      end
      drive(1'b1, abort == 1);
      e = blank(3'd0); e.mem_req = 1'b1; e.ir = 1'b1; e.pc = 1'b1;
      push(e, t);
      if (abort == 1) return;
      drive(1'($urandom), 1'b0);
      op = o;
      fun = f;
      e = blank(3'd1); e.ill = (k == K_ILL);
      push(e, t);
      if (k == K_ILL) return;
      if (k >= K_BEQ) begin
         drive(1'($urandom), 1'b0);
         equal = eq;
         sign = sg;
         if (k == K_BEQ)      tk = eq;
         else if (k == K_BNE) tk = !eq;
         else                 tk = !eq && !sg;
         e = blank(3'd5); e.alu = 3'd6; e.pc = tk; e.npc = tk;
         push(e, t);
         return;
      end
      drive(1'($urandom), 1'b0);
      e = blank(3'd2); e.alu = a;
      if (k == K_R) e.rd = 1'b1;
      else begin e.src = 1'b1; e.ext = 1'b1; end
      push(e, t);
      if (k == K_LW || k == K_SW) begin
         for (int i = 0; i < mw; i++) begin
            drive(1'b0, abort == 2);
            e = blank(3'd3); e.mem_req = 1'b1; e.mw = (k == K_SW);
            push(e, t);
            if (abort == 2) return;
         end
         drive(1'b1, 1'b0);
         e = blank(3'd3); e.mem_req = 1'b1; e.mw = (k == K_SW);
         push(e, t);
         if (k == K_SW) return;
      end
      drive(1'($urandom), 1'b0);
      e = blank(3'd4); e.rw = 1'b1;
      e.rd = (k == K_R); e.m2r = (k == K_LW);
      push(e, t);
   endtask

   task automatic rand_instr();
      int k, fw, mw, ab, idx;
      logic [5:0] o, f;
      logic [2:0] a;
      k  = $urandom_range(0, 7);
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 3);
      ab = 0;
      f  = 6'($urandom);
      a  = 3'd0;
      if (k == K_R) begin
         idx = $urandom_range(0, 8);
         o = 6'd0; f = r_fun[idx]; a = r_alu[idx];
      end else if (k == K_ILL) begin
         if ($urandom_range(0, 1) == 1) o = bad_op[$urandom_range(0, 3)];
         else begin o = 6'd0; f = bad_fn[$urandom_range(0, 2)]; end
      end else begin
         o = i_op[k]; a = i_alu[k];
      end
      if ($urandom_range(0, 19) == 0) ab = 1;
      else if ((k == K_LW || k == K_SW) && mw > 0 &&
               $urandom_range(0, 9) == 0) ab = 2;
      run(k, o, f, a, 1'($urandom), 1'($urandom), fw, mw, ab, "rand");
   endtask

   initial begin
      rst = 1'b1;
      mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      run(K_R, 6'd0, 6'b100000, 3'd2, 0, 0, 0, 0, 0, "add");
      run(K_LW, 6'b100011, 6'd0, 3'd4, 0, 0, 1, 2, 0, "lw_wait");
      run(K_BNE, 6'b000101, 6'd0, 3'd6, 0, 0, 0, 0, 0, "bne_taken");
      run(K_BNE, 6'b000101, 6'd0, 3'd6, 1, 0, 0, 0, 0, "bne_not");
      run(K_BGTZ, 6'b000111, 6'd0, 3'd6, 0, 1, 0, 0, 0, "bgtz_neg");
      run(K_BGTZ, 6'b000111, 6'd0, 3'd6, 0, 0, 0, 0, 0, "bgtz_pos");
      run(K_BEQ, 6'b000100, 6'd0, 3'd6, 1, 1, 0, 0, 0, "beq_taken");
      run(K_ILL, 6'b111111, 6'd0, 3'd0, 0, 0, 0, 0, 0, "ill_op");
      run(K_SW, 6'b101011, 6'd0, 3'd4, 0, 0, 0, 1, 2, "sw_rst_mem");
      run(K_R, 6'd0, 6'b000000, 3'd5, 0, 0, 0, 0, 1, "rst_fetch");
      run(K_ADDI, 6'b001000, 6'd0, 3'd2, 0, 0, 2, 0, 0, "addi");
      run(K_SW, 6'b101011, 6'd0, 3'd4, 0, 0, 0, 0, 0, "sw");
      run(K_R, 6'd0, 6'b101011, 3'd7, 0, 0, 0, 0, 0, "sltu");
      for (int n = 0; n < 300; n++) rand_instr();
      repeat (3) @(posedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: left=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
